pcileech_com_tx_arb: RTL
========================

Name: pcileech_com_tx_arb

Overview:
- Round-robin burst arbiter that shares the 32-bit COM TX write path (the clk-domain side of the COM TX FIFO) between N requesters (e.g. TLP readback, FIFO status, DRP readback).
- Grants one requester per burst, so a host-side burst never interleaves words from different sources.
- Sits between the requester FIFOs and the COM core write port; runs in the 100 MHz clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BURST_DW, 8, words per burst (8 = 256 bits, the host transfer granule).
- TIMEOUT, 255, idle cycles a granted requester may stall mid-burst before abort.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a word on req_data[i].
- req_data  in  N_REQ*32  word of requester i at bits [32*i+31:32*i].
- req_last  in  N_REQ  word is the final word of requester i's message.
- req_ready  out  N_REQ  word of requester i is consumed this cycle.
- tx_ready  in  1  downstream not almost-full.
- tx_data  out  32  registered word to COM TX FIFO.
- tx_wr_en  out  1  registered write strobe.
- grant_id  out  $clog2(N_REQ)  current or last owner.
- busy  out  1  state != IDLE.
- abort_pulse  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; word_cnt 0; stall_cnt 0.
- States: IDLE, XFER, PAD.
- IDLE:
  - If any req_valid, grant the first valid index searching from (last_grant+1) mod N_REQ, wrapping; on the first grant after reset, search from 0.
  - Set grant_id and go to XFER next cycle. No word moves in IDLE.
- XFER, word transfer:
  - xfer = req_valid[g] & tx_ready.
  - req_ready[g] = xfer (combinational); req_ready is 0 for all non-granted requesters.
  - On xfer: tx_data <= req_data[g], tx_wr_en <= 1, word_cnt++.
  - Otherwise tx_wr_en <= 0.
- XFER, burst end:
  - Ends on the xfer where word_cnt == BURST_DW-1: go to IDLE, word_cnt <= 0.
  - On xfer with req_last and word_cnt < BURST_DW-1: go to PAD if COM_TX_PAD_EN, else IDLE.
  - req_last on the final word of a full burst: go to IDLE, no pad.
- XFER, stall timeout:
  - stall_cnt increments each XFER cycle with req_valid[g] == 0.
  - stall_cnt clears on any xfer. tx_ready low does not count as a stall.
  - When stall_cnt reaches TIMEOUT: pulse abort_pulse, then treat as req_last (PAD or IDLE).
- PAD (feature only):
  - While tx_ready, emit 0x66665555 each cycle with word_cnt++ until word_cnt reaches BURST_DW, then go to IDLE.
  - req_ready is all 0 during PAD.
- Latency and flow control:
  - Request to first tx_wr_en is 2 cycles minimum (grant cycle + registered output).
  - Back-to-back bursts lose one idle cycle (IDLE re-arbitration).
  - tx_ready is sampled combinationally. Downstream almost_full must tolerate 1 in-flight word.
- Fairness: a requester that was just granted cannot be regranted while another is valid.
- Simultaneous req_last and word_cnt == BURST_DW-1: burst ends normally, no PAD.
- Reset mid-burst: immediate return to reset values; a partial burst is not padded.

Optional Feature:
- Macro: COM_TX_PAD_EN.
- Defined: PAD state is present. Short or aborted bursts are padded with 0x66665555 to BURST_DW words, so the host stream stays 32-byte aligned; the host discards the magic words.
- Undefined: PAD state is absent; short bursts end immediately and the host handles unaligned streams.

Decomposition:
- Package pcileech_com_pkg:
  - COM_MAGIC_PAD = 32'h66665555.
  - typedef enum tx_arb_state_t {IDLE, XFER, PAD}.
  - COM_BURST_DW_DEFAULT = 8.
- Sub-module pcileech_rr_pick: combinational round-robin priority encoder (req vector, last pointer -> index, found).

Test Plan:
- Single requester: 0 sends 8 words 0x1..0x8 with last on 0x8 -> exactly 8 tx_wr_en carrying 0x1..0x8, grant_id=0, then busy=0.
- All 4 valid continuously with 16 words each -> grant order 0,1,2,3,0,1,2,3, each burst 8 contiguous words from one source.
- Requester 2 sends 3 words with last, COM_TX_PAD_EN defined -> 3 data words then 5×0x66665555. Without the macro -> 3 words, return to IDLE.
- tx_ready deasserted for 10 cycles at word 4 -> no words lost or duplicated, no abort, stream resumes at word 5.
- Granted requester drops valid after word 2 for TIMEOUT=255 cycles -> abort_pulse at cycle 255, 6 pad words (macro on), next requester granted.
- rst asserted during word 5 of a burst -> next cycle all outputs 0; after release the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/pcileech_com_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_com_pkg
// Description : Shared types and constants for the COM TX burst arbiter.
//               COM_MAGIC_PAD  - filler word used to pad short bursts
//               COM_BURST_DW_DEFAULT - host transfer granule in 32-bit words
//               tx_arb_state_t - arbiter FSM encoding
// Revision    : 1.0 - initial release
// ============================================================================
package pcileech_com_pkg;

    localparam logic [31:0] COM_MAGIC_PAD        = 32'h66665555;
    localparam int          COM_BURST_DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2
    } tx_arb_state_t;

    // Index width that never collapses to zero bits for a single-entry vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcileech_com_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_com_tx_arb_if
// Description : Requester and COM TX write-port bundle of the TX arbiter.
//               req_valid/req_data/req_last/req_ready : N_REQ requester lanes,
//                   lane i data at req_data[32*i+31:32*i]
//               tx_ready/tx_data/tx_wr_en : COM TX FIFO write side
//               modport master : requesters + downstream FIFO (environment)
//               modport slave  : the arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface pcileech_com_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_ready;
    logic                tx_ready;
    logic [31:0]         tx_data;
    logic                tx_wr_en;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_wr_en
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_wr_en
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_com_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_rr_pick
// Description : Combinational round-robin priority encoder. Returns the first
//               asserted bit of req found searching upward from index start,
//               wrapping at N_REQ.
//               req   in  N_REQ   request vector
//               start in  IDX_W   first index to examine
//               idx   out IDX_W   selected index (0 when none found)
//               found out 1       at least one request asserted
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [IDX_W-1:0] start,
    output logic      [IDX_W-1:0] idx,
    output logic                  found
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Walk from the farthest candidate down to start so the closest one wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(start), k)]) begin
                idx   = wrap_idx(int'(start), k);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcileech_com_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_com_tx_arb
// Description : Round-robin burst arbiter sharing the 32-bit COM TX write path
//               between N_REQ requesters. One requester owns the path for a
//               whole burst of up to BURST_DW words, so host bursts never mix
//               sources. A granted requester that stalls TIMEOUT cycles is
//               aborted.
//               Optional build macro COM_TX_PAD_EN: short or aborted bursts
//               are filled with COM_MAGIC_PAD up to BURST_DW words.
// Ports       : clk, rst (sync, active-high)
//               bus         : requester lanes + COM TX write port (slave)
//               grant_id    : current or last burst owner
//               busy        : arbiter not idle
//               abort_pulse : one-cycle pulse on stall timeout
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_com_tx_arb
    import pcileech_com_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int BURST_DW = COM_BURST_DW_DEFAULT,
    parameter int TIMEOUT  = 255,
    localparam int GW      = clog2_min1(N_REQ),
    localparam int WCW     = $clog2(BURST_DW + 1),
    localparam int SCW     = $clog2(TIMEOUT + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    pcileech_com_tx_arb_if.slave      bus,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic                      abort_pulse
);

    // Destination after a burst ends early (req_last or timeout).
`ifdef COM_TX_PAD_EN
    localparam tx_arb_state_t c_short_end = PAD;
`else
    localparam tx_arb_state_t c_short_end = IDLE;
`endif

    tx_arb_state_t    r_state;
    tx_arb_state_t    w_state_nxt;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_rr_ptr;
    logic [WCW-1:0]   r_word_cnt;
    logic [SCW-1:0]   r_stall_cnt;
    logic [31:0]      r_tx_data;
    logic             r_tx_wr_en;
    logic             r_abort;

    logic [GW-1:0]    w_pick_idx;
    logic             w_pick_found;
    logic [GW-1:0]    w_ptr_nxt;
    logic             w_g_valid;
    logic             w_g_last;
    logic [31:0]      w_g_data;
    logic             w_xfer;
    logic             w_burst_full;
    logic             w_stall;
    logic             w_timeout;
    logic             w_pad_word;
    logic             w_emit;
    logic [31:0]      w_emit_data;
    logic [N_REQ-1:0] w_req_ready;

    pcileech_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (GW)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .start (r_rr_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    // The search pointer holds the index after the previous owner, so a
    // just-granted requester is examined last on the next arbitration.
    assign w_ptr_nxt = (w_pick_idx == GW'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

    assign w_g_valid    = bus.req_valid[r_grant];
    assign w_g_last     = bus.req_last[r_grant];
    assign w_g_data     = bus.req_data[int'(r_grant) * 32 +: 32];
    assign w_xfer       = (r_state == XFER) && w_g_valid && bus.tx_ready;
    assign w_burst_full = (r_word_cnt == WCW'(BURST_DW - 1));
    // Only a missing word counts as a stall; downstream backpressure does not.
    assign w_stall      = (r_state == XFER) && !w_g_valid;
    assign w_timeout    = w_stall && (r_stall_cnt == SCW'(TIMEOUT - 1));
`ifdef COM_TX_PAD_EN
    assign w_pad_word   = (r_state == PAD) && bus.tx_ready;
`else
    assign w_pad_word   = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_found) w_state_nxt = XFER;
            end
            XFER: begin
                if (w_xfer) begin
                    if (w_burst_full)  w_state_nxt = IDLE;
                    else if (w_g_last) w_state_nxt = c_short_end;
                end else if (w_timeout) begin
                    w_state_nxt = c_short_end;
                end
            end
            PAD: begin
                if (!w_pad_word || !w_burst_full) w_state_nxt = PAD;
                else                               w_state_nxt = IDLE;
`ifndef COM_TX_PAD_EN
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_req_ready = '0;
        w_emit      = 1'b0;
        w_emit_data = w_g_data;
        if (w_xfer) begin
            w_req_ready[r_grant] = 1'b1;
            w_emit               = 1'b1;
        end else if (w_pad_word) begin
            w_emit      = 1'b1;
            w_emit_data = COM_MAGIC_PAD;
        end
    end

    // ---------------- datapath / counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_word_cnt  <= '0;
            r_stall_cnt <= '0;
            r_tx_data   <= '0;
            r_tx_wr_en  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_tx_wr_en <= w_emit;
            if (w_emit) r_tx_data <= w_emit_data;
            r_abort <= w_timeout;

            if ((r_state == IDLE) && w_pick_found) begin
                r_grant  <= w_pick_idx;
                r_rr_ptr <= w_ptr_nxt;
            end

            // Counting continues into PAD; any return to IDLE restarts the burst.
            if (w_state_nxt == IDLE) r_word_cnt <= '0;
            else if (w_emit)         r_word_cnt <= r_word_cnt + 1'b1;

            if (w_xfer || (w_state_nxt != XFER)) r_stall_cnt <= '0;
            else if (w_stall)                    r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_wr_en  = r_tx_wr_en;
    assign grant_id      = r_grant;
    assign busy          = (r_state != IDLE);
    assign abort_pulse   = r_abort;

endmodule
`default_nettype wire
